sum4_sequencer: RTL and testbench

SUM4_SEQUENCER -- requirements
Module: sum4_sequencer

---
 rtl/sum4_sequencer.sv | 127 ++++++++++++
 tb/tb_sum4_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sum4_sequencer.sv
// Button-started sequencer that sums the four SW nibbles with one shared adder.
// Optional SUM4_DEBOUNCE_EN inserts a DEBOUNCE_CYCLES stability filter on BTNC.
module sum4_sequencer #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic        CLK100MHZ,
   input  logic        CPU_RESETN,
   input  logic [15:0] SW,
   input  logic        BTNC,
   output logic [5:0]  LED,
   output logic        BUSY,
   output logic        DONE
);

   typedef enum logic [1:0] {IDLE, LOAD, ADD, DONE_ST} state_t;

   state_t      state_q, state_d;
   logic        sync1_q, sync2_q;
   logic        level;
   logic        lvl_prev_q;
   logic        press_q;
   logic [15:0] opnd_q, opnd_d;
   logic [5:0]  acc_q, acc_d;
   logic [1:0]  idx_q, idx_d;
   logic [5:0]  led_q, led_d;
   logic [3:0]  nib;
   logic [5:0]  sum;

   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= BTNC;
         sync2_q <= sync1_q;
      end
   end

`ifdef SUM4_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic             level_q;

   // Level follows the synchronizer only after it has disagreed for a full run.
   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else if (sync2_q != level_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_q <= sync2_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_q <= '0;
      end
   end

   assign level = level_q;
`else
   assign level = sync2_q;
`endif

   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         lvl_prev_q <= 1'b0;
         press_q    <= 1'b0;
         state_q    <= IDLE;
         opnd_q     <= '0;
         acc_q      <= '0;
         idx_q      <= '0;
         led_q      <= '0;
      end else begin
         lvl_prev_q <= level;
         press_q    <= level & ~lvl_prev_q;
         state_q    <= state_d;
         opnd_q     <= opnd_d;
         acc_q      <= acc_d;
         idx_q      <= idx_d;
         led_q      <= led_d;
      end
   end

   // Single shared adder: 6-bit accumulator plus the selected zero-extended nibble.
   assign nib = opnd_q[{idx_q, 2'b00} +: 4];
   assign sum = acc_q + {2'b00, nib};

   always_comb begin
      state_d = state_q;
      opnd_d  = opnd_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      led_d   = led_q;
      case (state_q)
         IDLE: begin
            if (press_q) state_d = LOAD;
         end
         LOAD: begin
            opnd_d  = SW;
            acc_d   = '0;
            idx_d   = '0;
            state_d = ADD;
         end
         ADD: begin
            acc_d = sum;
            idx_d = idx_q + 2'd1;
            // LED is loaded with the final sum so it changes in the same cycle DONE is high.
            if (idx_q == 2'd3) begin
               led_d   = sum;
               state_d = DONE_ST;
            end
         end
         DONE_ST: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign LED  = led_q;
   assign BUSY = (state_q != IDLE);
   assign DONE = (state_q == DONE_ST);

endmodule

// File: tb/tb_sum4_sequencer.sv
// Randomized bench for sum4_sequencer: a timing/sum reference model checks LED, BUSY and DONE every cycle.
module tb_sum4_sequencer;

`ifdef SUM4_DEBOUNCE_EN
   localparam int DB   = 4;
   localparam int HOLD = 6;
`else
   localparam int DB   = 0;
   localparam int HOLD = 2;
`endif
   // Edges from the first BTNC-sampling edge to the press pulse.
   localparam int P = 3 + DB;

   logic        clk = 1'b0;
   logic        CPU_RESETN;
   logic [15:0] SW;
   logic        BTNC;
   logic [5:0]  LED;
   logic        BUSY;
   logic        DONE;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [5:0]  led_model = '0;

   sum4_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
      .CLK100MHZ (clk),
      .CPU_RESETN(CPU_RESETN),
      .SW        (SW),
      .BTNC      (BTNC),
      .LED       (LED),
      .BUSY      (BUSY),
      .DONE      (DONE)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One press transaction observed for P+12 cycles; optional mid-run SW change/re-press,
   // reset abort at cycle rst_at, or button held through a reset release.
   task automatic run_op(input logic [15:0] sw, input int hold, input bit repress,
                         input int rst_at, input bit rst_first);
      int         exp_sum;
      logic [5:0] old;
      bit         aborted;
      bit         busy_e, done_e;
      exp_sum = 0;
      aborted = 0;
      for (int i = 0; i < 4; i++) exp_sum += int'((sw >> (4 * i)) & 16'h000F);
      @(negedge clk);
      if (rst_first) begin
         BTNC       = 1'b1;
         CPU_RESETN = 1'b0;
         repeat (3) @(negedge clk);
         chk("rst_led", LED, 0);
         chk("rst_busy", BUSY, 0);
         chk("rst_done", DONE, 0);
         led_model  = '0;
         CPU_RESETN = 1'b1;
      end
      SW   = sw;
      BTNC = 1'b1;
      old  = led_model;
      for (int j = 1; j <= P + 12; j++) begin
         @(posedge clk);
         @(negedge clk);
         if (rst_at != 0 && j == rst_at + 1) begin
            chk("abort_led", LED, 0);
            chk("abort_busy", BUSY, 0);
            chk("abort_done", DONE, 0);
            aborted   = 1;
            led_model = '0;
         end else if (aborted) begin
            chk("post_abort_busy", BUSY, 0);
            chk("post_abort_done", DONE, 0);
            chk("post_abort_led", LED, 0);
         end else begin
            busy_e = (j >= P + 1) && (j <= P + 6);
            done_e = (j == P + 6);
            chk("busy", BUSY, busy_e);
            chk("done", DONE, done_e);
            chk("led", LED, (j >= P + 6) ? exp_sum : old);
         end
         if (j == hold) BTNC = 1'b0;
         if (repress && j == P + 2) begin
            SW = 16'hFFFF;
`ifndef SUM4_DEBOUNCE_EN
            BTNC = 1'b1;
`endif
         end
         if (repress && j == P + 3) BTNC = 1'b0;
         if (rst_at != 0 && j == rst_at) CPU_RESETN = 1'b0;
         if (rst_at != 0 && j == rst_at + 1) CPU_RESETN = 1'b1;
      end
      if (!aborted) led_model = exp_sum[5:0];
   endtask

   initial begin
      CPU_RESETN = 1'b0;
      SW         = '0;
      BTNC       = 1'b0;
      repeat (3) @(negedge clk);
      chk("init_led", LED, 0);
      chk("init_busy", BUSY, 0);
      chk("init_done", DONE, 0);
      CPU_RESETN = 1'b1;
      repeat (3) @(negedge clk);

      run_op(16'h4321, HOLD, 0, 0, 0);
      run_op(16'hFFFF, HOLD, 0, 0, 0);
      run_op(16'h0000, HOLD, 0, 0, 0);
      run_op(16'h1111, HOLD, 1, 0, 0);
      run_op(16'hFFFF, HOLD, 0, 0, 0);
      run_op(16'h5A3C, HOLD, 0, P + 3, 0);
      run_op(16'hFFFF, HOLD, 0, 0, 0);
      run_op(16'h8421, P + 4, 0, 0, 1);

`ifdef SUM4_DEBOUNCE_EN
      for (int r = 0; r < 3; r++) begin
         BTNC = 1'b1;
         repeat (2) begin
            @(negedge clk);
            chk("glitch_busy", BUSY, 0);
            chk("glitch_done", DONE, 0);
         end
         BTNC = 1'b0;
         repeat (3) begin
            @(negedge clk);
            chk("glitch_busy", BUSY, 0);
            chk("glitch_done", DONE, 0);
         end
      end
      repeat (8) begin
         @(negedge clk);
         chk("glitch_idle", BUSY, 0);
      end
      run_op(16'h8421, 10, 0, 0, 0);
`endif

      for (int k = 0; k < 8; k++) begin
         run_op(16'($urandom), HOLD + int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)), 0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
